// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the configuration register bank arbiter.
package reg_arb_pkg;

  // Per-cycle owner of the single bank write/read port.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_SPI,
    GNT_CORE
  } gnt_e;

  // Consecutive denied cycles after which the core takes priority over SPI.
  localparam int unsigned DefaultMaxWait = 4;

endpackage

// File: rtl/reg_wr_pend_buf.sv
// One-deep holding buffer for SPI write strobes. The SPI side cannot be
// stalled, so a strobe that arrives while an undrained entry is held is lost
// and reported on drop.
module reg_wr_pend_buf #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wvld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              drain,
  output logic              pend_vld,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [WIDTH-1:0]  pend_data,
  output logic              drop
);

  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              cap;

  // Next-state: capture into a free or simultaneously-drained slot, else drop.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    cap    = ena & wvld;
    drop   = cap & vld_q & ~drain;
    if (cap && (!vld_q || drain)) begin
      vld_d  = 1'b1;
      addr_d = addr;
      data_d = wdata;
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign pend_vld  = vld_q;
  assign pend_addr = addr_q;
  assign pend_data = data_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Configuration register bank shared between the SPI register slave (via a
// one-deep pending buffer) and a core req/gnt port, with bounded core
// starvation.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned MAX_WAIT = DefaultMaxWait
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      spi_wvld,
  input  logic [ADDR_W-1:0]         spi_addr,
  input  logic [WIDTH-1:0]          spi_wdata,
  output logic [WIDTH-1:0]          spi_rdata,
  input  logic                      core_req,
  input  logic                      core_we,
  input  logic [ADDR_W-1:0]         core_addr,
  input  logic [WIDTH-1:0]          core_wdata,
  output logic                      core_gnt,
  output logic [WIDTH-1:0]          core_rdata,
  output logic                      core_rvld,
  input  logic                      drop_clr,
  output logic                      spi_drop,
  output logic                      busy,
  output logic [NUM_REGS*WIDTH-1:0] config_regs
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [WIDTH-1:0]  mem_q [NUM_REGS];
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [WIDTH-1:0]  pend_data;
  logic              drop_det;
  logic              drain;
  gnt_e              gnt;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [WIDTH-1:0]  core_rdata_q;
  logic              core_rvld_q;
  logic              drop_q;
  logic              pend_in_rng, core_in_rng, spi_in_rng;

  assign pend_in_rng = 32'(pend_addr) < NUM_REGS;
  assign core_in_rng = 32'(core_addr) < NUM_REGS;
  assign spi_in_rng  = 32'(spi_addr) < NUM_REGS;

  reg_wr_pend_buf #(
    .ADDR_W(ADDR_W),
    .WIDTH (WIDTH)
  ) u_pend_buf (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .wvld     (spi_wvld),
    .addr     (spi_addr),
    .wdata    (spi_wdata),
    .drain    (drain),
    .pend_vld (pend_vld),
    .pend_addr(pend_addr),
    .pend_data(pend_data),
    .drop     (drop_det)
  );

  // Grant selection; rst gates the combinational grant so it drops immediately.
  always_comb begin
    gnt = GNT_NONE;
    if (ena && !rst) begin
      if (pend_vld && core_req) begin
        gnt = (starve_q == CntW'(MAX_WAIT)) ? GNT_CORE : GNT_SPI;
      end else if (pend_vld) begin
        gnt = GNT_SPI;
      end else if (core_req) begin
        gnt = GNT_CORE;
      end
    end
  end

  assign drain    = (gnt == GNT_SPI);
  assign core_gnt = (gnt == GNT_CORE);

  // Starvation count: cycles the core has been held off by SPI; frozen while disabled.
  always_comb begin
    starve_d = starve_q;
    if (ena) begin
      if (!core_req || gnt == GNT_CORE) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Bank write port; out-of-range addresses are consumed without effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (gnt)
        GNT_SPI: begin
          if (pend_in_rng) begin
            mem_q[pend_addr] <= pend_data;
          end
        end
        GNT_CORE: begin
          if (core_we && core_in_rng) begin
            mem_q[core_addr] <= core_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Core read data and its one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata_q <= '0;
      core_rvld_q  <= 1'b0;
    end else begin
      core_rvld_q <= (gnt == GNT_CORE) && !core_we;
      if (gnt == GNT_CORE && !core_we) begin
        core_rdata_q <= core_in_rng ? mem_q[core_addr] : '0;
      end
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (drop_det) begin
      drop_q <= 1'b1;
    end else if (drop_clr) begin
      drop_q <= 1'b0;
    end
  end

  // SPI read-back sees a pending write to the same address before it lands.
  always_comb begin
    spi_rdata = '0;
    if (spi_in_rng) begin
      if (pend_vld && pend_addr == spi_addr) begin
        spi_rdata = pend_data;
      end else begin
        spi_rdata = mem_q[spi_addr];
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
    assign config_regs[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign core_rdata = core_rdata_q;
  assign core_rvld  = core_rvld_q;
  assign spi_drop   = drop_q;
  assign busy       = pend_vld;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter, built with six registers so that
// out-of-range addresses exist.
module tb_reg_bank_arbiter;

  localparam int unsigned NR = 6;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk, rst, ena;
  logic          spi_wvld;
  logic [AW-1:0] spi_addr;
  logic [W-1:0]  spi_wdata, spi_rdata;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [W-1:0]  core_wdata, core_rdata;
  logic          core_gnt, core_rvld;
  logic          drop_clr, spi_drop, busy;
  logic [NR*W-1:0] config_regs;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(
    .NUM_REGS(NR),
    .WIDTH   (W),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spi_wvld   (spi_wvld),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_rdata  (spi_rdata),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rdata (core_rdata),
    .core_rvld  (core_rvld),
    .drop_clr   (drop_clr),
    .spi_drop   (spi_drop),
    .busy       (busy),
    .config_regs(config_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive point just after the active edge; check point at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] cfg(input int i);
    return config_regs[i*W +: W];
  endfunction

  task automatic spi_wr(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    spi_wvld  = v;
    spi_addr  = a;
    spi_wdata = d;
  endtask

  task automatic core(input logic r, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d);
    core_req   = r;
    core_we    = we;
    core_addr  = a;
    core_wdata = d;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; drop_clr = 1'b0;
    spi_wr(0, 0, 0);
    core(0, 0, 0, 0);
    mid();
    check("rst_busy", busy, 0);
    check("rst_gnt", core_gnt, 0);
    check("rst_rvld", core_rvld, 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_drop", spi_drop, 0);
    check("rst_cfg", config_regs, 0);
    cyc();
    rst = 1'b0;

    // 1: SPI write reg3 = A5
    cyc(); spi_wr(1, 3, 8'hA5);
    mid(); check("t1_busy_c0", busy, 0);
    cyc(); spi_wr(0, 0, 0);
    mid(); check("t1_busy_c1", busy, 1); check("t1_cfg3_c1", cfg(3), 8'h00);
    cyc();
    mid(); check("t1_busy_c2", busy, 0); check("t1_cfg3_c2", cfg(3), 8'hA5);

    // 2: core read reg3 while idle
    cyc(); core(1, 0, 3, 0);
    mid(); check("t2_gnt", core_gnt, 1); check("t2_rvld_c0", core_rvld, 0);
    cyc(); core(0, 0, 0, 0);
    mid(); check("t2_rvld", core_rvld, 1); check("t2_rdata", core_rdata, 8'hA5);
    cyc();
    mid(); check("t2_rvld_off", core_rvld, 0);

    // 3: core write held against SPI strobes every other cycle
    cyc(); spi_wr(1, 2, 8'h40);
    mid(); check("t3_gnt_k0", core_gnt, 0);
    cyc(); spi_wr(0, 2, 0); core(1, 1, 1, 8'h11);
    mid(); check("t3_gnt_k1", core_gnt, 0);
    cyc(); spi_wr(1, 2, 8'h42);
    mid(); check("t3_gnt_k2", core_gnt, 1);
    cyc(); spi_wr(0, 0, 0); core(0, 0, 0, 0);
    mid(); check("t3_busy_k3", busy, 1);
    cyc();
    mid();
    check("t3_drop", spi_drop, 0);
    check("t3_cfg1", cfg(1), 8'h11);
    check("t3_cfg2", cfg(2), 8'h42);

    // 4: continuous strobes starve the core until the limit, then one drop
    for (int k = 0; k < 6; k++) begin
      cyc();
      spi_wr(1, 0, 8'h50 + 8'(k));
      if (k >= 1) core(1, 1, 4, 8'h44);
      mid();
      check($sformatf("t4_gnt_k%0d", k), core_gnt, (k == 5) ? 1 : 0);
    end
    cyc(); spi_wr(0, 0, 0); core(0, 0, 0, 0);
    mid(); check("t4_drop_set", spi_drop, 1); check("t4_gnt_k6", core_gnt, 0);
    cyc();
    mid();
    check("t4_cfg0", cfg(0), 8'h54);
    check("t4_cfg4", cfg(4), 8'h44);
    check("t4_drop_hold", spi_drop, 1);
    drop_clr = 1'b1;
    cyc(); drop_clr = 1'b0;
    mid(); check("t4_drop_clr", spi_drop, 0);

    // 5: pending read-back, disabled strobe, out-of-range accesses
    cyc(); spi_wr(1, 5, 8'h3C);
    cyc(); ena = 1'b0; spi_wr(1, 2, 8'hFF); spi_addr = 5;
    mid();
    check("t5_fwd", spi_rdata, 8'h3C);
    check("t5_busy", busy, 1);
    check("t5_cfg5_pend", cfg(5), 8'h00);
    cyc(); ena = 1'b1; spi_wvld = 1'b0; spi_addr = 5; core(1, 1, 7, 8'h77);
    mid();
    check("t5_gnt_spi_first", core_gnt, 0);
    check("t5_dis_nodrop", spi_drop, 0);
    cyc(); spi_addr = 7;
    mid(); check("t5_gnt_oor", core_gnt, 1); check("t5_spi_oor", spi_rdata, 0);
    cyc(); core(1, 0, 6, 0);
    mid(); check("t5_gnt_rd_oor", core_gnt, 1);
    cyc(); core(0, 0, 0, 0);
    mid();
    check("t5_rvld_oor", core_rvld, 1);
    check("t5_rdata_oor", core_rdata, 0);
    check("t5_cfg_all", config_regs, 48'h3C_44_A5_42_11_54);

    // 6: reset in the middle of a cycle with a pending write and a core write
    cyc(); spi_wr(1, 1, 8'h99);
    cyc(); spi_wr(0, 0, 0); core(1, 1, 2, 8'h88);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_gnt", core_gnt, 0);
    check("t6_rvld", core_rvld, 0);
    check("t6_rdata", core_rdata, 0);
    check("t6_cfg", config_regs, 0);
    cyc(); core(0, 0, 0, 0);
    cyc(); rst = 1'b0;
    cyc();
    mid();
    check("t6_cfg_after", config_regs, 0);
    check("t6_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
